pe_layer_ctrl: RTL and testbench

PE_LAYER_CTRL -- requirements
Module: pe_layer_ctrl

---
 rtl/pe_layer_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pe_layer_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_layer_ctrl.sv
// Layer sequencer for one processing element: fetches weights/bias per neuron, evaluates, hands results off.
// Optional running argmax of the layer's results is enabled with `define PE_LAYER_CTRL_ARGMAX_EN.
module pe_layer_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] layer_size,
  input  logic [495:0]      in_vec,
  output logic              busy,
  output logic              done,
  output logic              wb_rd_en,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic [503:0]      wb_rdata,
  output logic [7:0]        pe_bias,
  output logic [495:0]      pe_weight,
  output logic [495:0]      pe_in,
  input  logic [7:0]        pe_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] res_addr,
  output logic [7:0]        res_data
`ifdef PE_LAYER_CTRL_ARGMAX_EN
  ,
  output logic [ADDR_W-1:0] argmax_idx,
  output logic [7:0]        argmax_val
`endif
);

  localparam int unsigned VEC_W  = 496;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    EVAL  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   n_q, n_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic                busy_d, done_d, wb_rd_en_d;
  logic [BYTE_W-1:0]   pe_bias_d;
  logic [VEC_W-1:0]    pe_weight_d, pe_in_d;
  logic                res_valid_d;
  logic [ADDR_W-1:0]   res_addr_d;
  logic [BYTE_W-1:0]   res_data_d;
`ifdef PE_LAYER_CTRL_ARGMAX_EN
  logic [ADDR_W-1:0]   argmax_idx_d;
  logic [BYTE_W-1:0]   argmax_val_d;
`endif

  // The neuron index is the fetch address at all times.
  assign wb_addr = n_q;

  // Next-state and next-register values.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    count_d     = count_q;
    pe_bias_d   = pe_bias;
    pe_weight_d = pe_weight;
    pe_in_d     = pe_in;
    res_valid_d = res_valid;
    res_addr_d  = res_addr;
    res_data_d  = res_data;
`ifdef PE_LAYER_CTRL_ARGMAX_EN
    argmax_idx_d = argmax_idx;
    argmax_val_d = argmax_val;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          pe_in_d = in_vec;
          count_d = layer_size;
          n_d     = '0;
`ifdef PE_LAYER_CTRL_ARGMAX_EN
          argmax_idx_d = '0;
          argmax_val_d = '0;
`endif
          state_d = (layer_size == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        pe_bias_d   = wb_rdata[VEC_W +: BYTE_W];
        pe_weight_d = wb_rdata[VEC_W-1:0];
        state_d     = EVAL;
      end
      EVAL: begin
        res_data_d  = pe_out;
        res_addr_d  = n_q;
        res_valid_d = 1'b1;
        state_d     = WRITE;
      end
      WRITE: begin
        if (res_valid && res_ready) begin
          res_valid_d = 1'b0;
`ifdef PE_LAYER_CTRL_ARGMAX_EN
          // Strict compare keeps the lowest index on ties.
          if (res_data > argmax_val) begin
            argmax_idx_d = res_addr;
            argmax_val_d = res_data;
          end
`endif
          if (n_q == count_q - ADDR_W'(1)) begin
            state_d = DONE;
          end else begin
            n_d     = n_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    wb_rd_en_d = (state_d == FETCH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      count_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wb_rd_en   <= 1'b0;
      pe_bias    <= '0;
      pe_weight  <= '0;
      pe_in      <= '0;
      res_valid  <= 1'b0;
      res_addr   <= '0;
      res_data   <= '0;
`ifdef PE_LAYER_CTRL_ARGMAX_EN
      argmax_idx <= '0;
      argmax_val <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      count_q    <= count_d;
      busy       <= busy_d;
      done       <= done_d;
      wb_rd_en   <= wb_rd_en_d;
      pe_bias    <= pe_bias_d;
      pe_weight  <= pe_weight_d;
      pe_in      <= pe_in_d;
      res_valid  <= res_valid_d;
      res_addr   <= res_addr_d;
      res_data   <= res_data_d;
`ifdef PE_LAYER_CTRL_ARGMAX_EN
      argmax_idx <= argmax_idx_d;
      argmax_val <= argmax_val_d;
`endif
    end
  end

endmodule

// File: tb/tb_pe_layer_ctrl.sv
// Self-checking bench for pe_layer_ctrl: weight memory and PE models, table-driven passes with a result scoreboard.
module tb_pe_layer_ctrl;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] layer_size;
  logic [495:0]      in_vec;
  logic              busy, done, wb_rd_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [503:0]      wb_rdata = '0;
  logic [7:0]        pe_bias;
  logic [495:0]      pe_weight, pe_in;
  logic [7:0]        pe_out;
  logic              res_valid, res_ready;
  logic [ADDR_W-1:0] res_addr;
  logic [7:0]        res_data;
`ifdef PE_LAYER_CTRL_ARGMAX_EN
  logic [ADDR_W-1:0] argmax_idx;
  logic [7:0]        argmax_val;
`endif

  always #5 clk = ~clk;

  pe_layer_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer_size(layer_size), .in_vec(in_vec),
    .busy(busy), .done(done), .wb_rd_en(wb_rd_en), .wb_addr(wb_addr), .wb_rdata(wb_rdata),
    .pe_bias(pe_bias), .pe_weight(pe_weight), .pe_in(pe_in), .pe_out(pe_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_data(res_data)
`ifdef PE_LAYER_CTRL_ARGMAX_EN
    , .argmax_idx(argmax_idx), .argmax_val(argmax_val)
`endif
  );

  // Weight memory: bias per neuron, weight low byte fixed at 3*index.
  logic [7:0] mem_bias [256];
  logic [7:0] want [256];

  function automatic logic [7:0] w0_of(input logic [7:0] a);
    return 8'(a * 3);
  endfunction

  always @(posedge clk) if (wb_rd_en) wb_rdata <= {mem_bias[wb_addr], {62{w0_of(wb_addr)}}};

  // PE model: result depends on bias, weight low byte and top activation byte.
  assign pe_out = pe_bias + pe_weight[7:0] + pe_in[495:488];

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [7:0]       size;
    logic [7:0]       top;
    logic [3:0][7:0]  r;
    int               stall;
    int               glitch;
    int               exp_done;
    logic [7:0]       ax_idx;
    logic [7:0]       ax_val;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [495:0] rand_vec();
    logic [495:0] v;
    for (int i = 0; i < 15; i++) v[i*32 +: 32] = $urandom();
    v[480 +: 16] = 16'($urandom());
    return v;
  endfunction

  task automatic load_mem(input logic [7:0] size, input logic [7:0] top);
    for (int i = 0; i < int'(size); i++) mem_bias[i] = want[i] - w0_of(8'(i)) - top;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " wb_rd_en"}, 32'(wb_rd_en), 32'd0);
    chk({tag, " wb_addr"}, 32'(wb_addr), 32'd0);
    chk({tag, " pe_bias"}, 32'(pe_bias), 32'd0);
    chk({tag, " pe_weight"}, 32'(|pe_weight), 32'd0);
    chk({tag, " pe_in"}, 32'(|pe_in), 32'd0);
    chk({tag, " res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, " res_addr"}, 32'(res_addr), 32'd0);
    chk({tag, " res_data"}, 32'(res_data), 32'd0);
`ifdef PE_LAYER_CTRL_ARGMAX_EN
    chk({tag, " argmax_idx"}, 32'(argmax_idx), 32'd0);
    chk({tag, " argmax_val"}, 32'(argmax_val), 32'd0);
`endif
  endtask

  // One layer pass; results expected in want[0..size-1].
  task automatic run_pass(input logic [7:0] size, input logic [7:0] top, input int stall,
                          input int glitch, input int exp_done, input logic [7:0] ax_idx,
                          input logic [7:0] ax_val, input string tag);
    int c, done_cyc, done_cnt, rd_cnt, hs_cnt, stall_left;
    bit fin;
    logic [495:0] rv;
    c = 0; done_cyc = -1; done_cnt = 0; rd_cnt = 0; hs_cnt = 0; fin = 1'b0;
    stall_left = stall;
    load_mem(size, top);
    for (int i = 0; i < int'(size); i++) sb_q.push_back(exp_t'{addr: 8'(i), data: want[i]});
    @(negedge clk);
    rv = rand_vec();
    start = 1'b1; layer_size = size; in_vec = {top, rv[487:0]};
    res_ready = (stall == 0);
    @(posedge clk);
    #1;
    start = 1'b0; layer_size = ~size; in_vec = rand_vec();
    while (!fin) begin
      @(negedge clk);
      c++;
      if (c == 1) chk({tag, " busy"}, 32'(busy), 32'd1);
      if (glitch != 0 && c == glitch) begin start = 1'b1; layer_size = 8'd5; end
      else start = 1'b0;
      if (wb_rd_en) begin
        chk({tag, " rd_addr"}, 32'(wb_addr), 32'(rd_cnt));
        rd_cnt++;
      end
      if (res_valid) begin
        if (stall_left > 0) begin stall_left--; res_ready = 1'b0; end
        else res_ready = 1'b1;
        if (sb_q.size() != 0) begin
          chk({tag, " res_data"}, 32'(res_data), 32'(sb_q[0].data));
          chk({tag, " res_addr"}, 32'(res_addr), 32'(sb_q[0].addr));
          if (res_ready) void'(sb_q.pop_front());
        end
        if (res_ready) hs_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 4) fin = 1'b1;
      if (c >= 1200) begin
        chk({tag, " timeout"}, 32'(c), 32'(exp_done));
        fin = 1'b1;
      end
    end
    res_ready = 1'b1;
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, " rd_count"}, 32'(rd_cnt), 32'(size));
    chk({tag, " result_count"}, 32'(hs_cnt), 32'(size));
    chk({tag, " scoreboard_left"}, 32'(sb_q.size()), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
`ifdef PE_LAYER_CTRL_ARGMAX_EN
    chk({tag, " argmax_idx"}, 32'(argmax_idx), 32'(ax_idx));
    chk({tag, " argmax_val"}, 32'(argmax_val), 32'(ax_val));
`else
    if (ax_idx > 8'd255 || ax_val > 8'd255) $display("argmax args out of range");
`endif
    sb_q.delete();
  endtask

  vec_t tbl [7];

  initial begin
    logic [7:0] mx, mi;
    logic [495:0] rv;
    rst_n = 1'b0; start = 1'b0; layer_size = '0; in_vec = '0; res_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin mem_bias[i] = '0; want[i] = '0; end

    //            size   top    r3 r2 r1 r0                     stall glitch done ax_idx ax_val
    tbl[0] = '{8'd3, 8'h11, {8'd0, 8'd2, 8'd9, 8'd5},       0, 0, 13, 8'd1, 8'd9};
    tbl[1] = '{8'd0, 8'h22, {8'd0, 8'd0, 8'd0, 8'd0},       0, 0, 1,  8'd0, 8'd0};
    tbl[2] = '{8'd2, 8'h33, {8'd0, 8'd0, 8'd20, 8'd10},     5, 0, 14, 8'd1, 8'd20};
    tbl[3] = '{8'd3, 8'h44, {8'd0, 8'd3, 8'd7, 8'd7},       0, 0, 13, 8'd0, 8'd7};
    tbl[4] = '{8'd1, 8'hf0, {8'd0, 8'd0, 8'd0, 8'd200},     0, 0, 5,  8'd0, 8'd200};
    tbl[5] = '{8'd4, 8'h01, {8'd255, 8'd255, 8'd0, 8'd1},   0, 0, 17, 8'd2, 8'd255};
    tbl[6] = '{8'd3, 8'h5a, {8'd0, 8'd6, 8'd8, 8'd4},       0, 7, 13, 8'd1, 8'd8};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 4; i++) want[i] = tbl[v].r[i];
      run_pass(tbl[v].size, tbl[v].top, tbl[v].stall, tbl[v].glitch, tbl[v].exp_done,
               tbl[v].ax_idx, tbl[v].ax_val, $sformatf("vec%0d", v));
    end

    // Largest layer: index must reach 254 without wrapping.
    mx = '0; mi = '0;
    for (int i = 0; i < 255; i++) begin
      want[i] = 8'(i) ^ 8'h3c;
      if (want[i] > mx) begin mx = want[i]; mi = 8'(i); end
    end
    run_pass(8'd255, 8'h77, 0, 0, 1021, mi, mx, "full");

    // Reset during the second neuron's WRITE abandons the pass.
    want[0] = 8'd3; want[1] = 8'd4; want[2] = 8'd5;
    load_mem(8'd3, 8'h20);
    @(negedge clk);
    rv = rand_vec();
    start = 1'b1; layer_size = 8'd3; in_vec = {8'h20, rv[487:0]};
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst res_valid", 32'(res_valid), 32'd1);
    chk("midrst res_addr", 32'(res_addr), 32'd1);
    chk("midrst res_data", 32'(res_data), 32'd4);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst no_done", 32'(done), 32'd0);
    end
    want[0] = 8'd42;
    run_pass(8'd1, 8'h05, 0, 0, 5, 8'd0, 8'd42, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
